// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer that shares one sequential multiplier among NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a watchdog that ends a stalled multiply with rsp_err=1.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_res,
  output logic                  rsp_err,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_res,
  input  logic                  mul_done,
  output logic                  busy
);
  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [WIDTH-1:0]       mul_a_q, mul_a_d;
  logic [WIDTH-1:0]       mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0]     rsp_res_q, rsp_res_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                   mul_start_q, mul_start_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand_idx;
  int                     cand;
  logic [WIDTH-1:0]       pick_a, pick_b;
  logic [NREQ-1:0]        pick_oh, owner_oh;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]        cnt_q, cnt_d;
  logic                   rsp_err_q, rsp_err_d;
`endif

  // Search starts just after the last served requester so it drops to lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(last_q) + 1 + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_a = '0;
    pick_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_idx == IDX_W'(j)) begin
        pick_a = req_a[j*WIDTH +: WIDTH];
        pick_b = req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  assign pick_oh  = NREQ'(1) << pick_idx;
  assign owner_oh = NREQ'(1) << owner_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_res_d   = rsp_res_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    mul_start_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    cnt_d       = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = ISSUE;
          owner_d     = pick_idx;
          mul_a_d     = pick_a;
          mul_b_d     = pick_b;
          gnt_d       = pick_oh;
          mul_start_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          state_d     = RESP;
          rsp_res_d   = mul_res;
          rsp_valid_d = owner_oh;
`ifdef MULT_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_res_d   = '0;
          rsp_valid_d = owner_oh;
          rsp_err_d   = 1'b1;
`endif
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_res_q   <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_res_q   <= rsp_res_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a small fixed-latency multiplier model attached.
module tb_mult_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_res;
  logic                  rsp_err;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_res;
  logic                  mul_done;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(mul_res), .mul_done(mul_done), .busy(busy)
  );

  // Sequential multiplier model: done pulses LAT cycles after start is seen.
  int          mdl_cnt = 0;
  logic        mdl_en = 1'b1;
  logic        stale_done = 1'b0;
  logic [31:0] mdl_prod = '0;

  always @(posedge clk) begin
    if (mul_start && mdl_en) begin
      mdl_cnt  <= LAT;
      mdl_prod <= mul_a * mul_b;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  assign mul_done = (mdl_cnt == 1) | stale_done;
  assign mul_res  = mdl_prod;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int i);
    return 64'd1 << i;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    req = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_gnt(input string tag);
    int cyc;
    cyc = 0;
    while (gnt == '0 && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, "_gnt_seen"}, 64'(gnt != '0), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, output int cyc);
    cyc = 0;
    while (rsp_valid == '0 && cyc < 200) begin
      step();
      cyc++;
    end
    check({tag, "_rsp_seen"}, 64'(rsp_valid != '0), 64'd1);
  endtask

  initial begin
    int cyc;
    int exp2[4];
    int seq3[6];
    logic [NREQ-1:0] acc_v;
    logic [NREQ-1:0] acc_g;
    logic acc_b;
    logic all_busy;
    exp2 = '{6, 9, 12, 15};
    seq3 = '{1, 3, 1, 3, 1, 3};

    // Reset state
    step();
    step();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_res", 64'(rsp_res), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // Test 1: single op with cycle-exact timing
    set_op(0, 16'h0181, 16'hFFFF);
    req = 4'b0001;
    step();
    check("t1_gnt", 64'(gnt), 64'd1);
    check("t1_start", 64'(mul_start), 64'd1);
    check("t1_mul_a", 64'(mul_a), 64'h0181);
    check("t1_mul_b", 64'(mul_b), 64'hFFFF);
    check("t1_busy", 64'(busy), 64'd1);
    req = '0;
    set_op(0, 16'h1111, 16'h2222);
    step();
    check("t1_gnt_pulse", 64'(gnt), 64'd0);
    check("t1_start_pulse", 64'(mul_start), 64'd0);
    check("t1_mul_a_held", 64'(mul_a), 64'h0181);
    step();
    step();
    check("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    step();
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_res", 64'(rsp_res), 64'h0180FE7F);
    check("t1_rsp_err", 64'(rsp_err), 64'd0);
    step();
    check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_res_hold", 64'(rsp_res), 64'h0180FE7F);

    // Test 2: all four requesters after reset, served in order 0..3
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 2), 16'd3);
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      wait_gnt("t2");
      check("t2_gnt_order", 64'(gnt), oh(i));
      req[i] = 1'b0;
      wait_rsp("t2", cyc);
      check("t2_rsp_owner", 64'(rsp_valid), oh(i));
      check("t2_rsp_res", 64'(rsp_res), 64'(exp2[i]));
    end

    // Test 3: requesters 1 and 3 holding req alternate
    do_reset();
    set_op(1, 16'd10, 16'd10);
    set_op(3, 16'd20, 16'd20);
    req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      wait_gnt("t3");
      check("t3_gnt_order", 64'(gnt), oh(seq3[k]));
      if (k >= 4) req[seq3[k]] = 1'b0;
      wait_rsp("t3", cyc);
      check("t3_rsp_owner", 64'(rsp_valid), oh(seq3[k]));
    end
    acc_g = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      acc_g |= gnt;
    end
    check("t3_no_extra_gnt", 64'(acc_g), 64'd0);

    // Test 4: reset while waiting on the multiplier, stale done ignored
    do_reset();
    set_op(1, 16'd5, 16'd5);
    req = 4'b0010;
    wait_gnt("t4a");
    req = '0;
    step();
    check("t4_in_wait_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_mul_a", 64'(mul_a), 64'd0);
    check("t4_rst_mul_b", 64'(mul_b), 64'd0);
    check("t4_rst_gnt", 64'(gnt), 64'd0);
    check("t4_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    reset_n = 1'b1;
    acc_v = '0;
    acc_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      stale_done = (c == 5);
      step();
      acc_v |= rsp_valid;
      acc_b |= busy;
    end
    stale_done = 1'b0;
    check("t4_no_rsp_after_abort", 64'(acc_v), 64'd0);
    check("t4_stale_done_ignored", 64'(acc_b), 64'd0);
    set_op(2, 16'd7, 16'd6);
    req = 4'b0100;
    wait_gnt("t4b");
    check("t4_gnt", 64'(gnt), 64'd4);
    req = '0;
    wait_rsp("t4b", cyc);
    check("t4_rsp_owner", 64'(rsp_valid), 64'd4);
    check("t4_rsp_res", 64'(rsp_res), 64'd42);

    // Test 5: zero operands; pointer wraps from 2 to 0
    set_op(0, 16'd0, 16'd13);
    set_op(1, 16'd5, 16'd0);
    req = 4'b0011;
    wait_gnt("t5a");
    check("t5_gnt0", 64'(gnt), 64'd1);
    req[0] = 1'b0;
    wait_rsp("t5a", cyc);
    check("t5_rsp0_owner", 64'(rsp_valid), 64'd1);
    check("t5_rsp0_res", 64'(rsp_res), 64'd0);
    step();
    check("t5_busy_gap", 64'(busy), 64'd0);
    wait_gnt("t5b");
    check("t5_gnt1", 64'(gnt), 64'd2);
    check("t5_busy_op", 64'(busy), 64'd1);
    req[1] = 1'b0;
    set_op(0, 16'd1, 16'd1);
    wait_rsp("t5b", cyc);
    check("t5_rsp1_owner", 64'(rsp_valid), 64'd2);
    check("t5_rsp1_res", 64'(rsp_res), 64'd0);
    check("t5_rsp1_err", 64'(rsp_err), 64'd0);
    step();
    check("t5_busy_end", 64'(busy), 64'd0);

    // Test 6: multiplier never completes
    mdl_en = 1'b0;
    set_op(2, 16'd9, 16'd9);
    req = 4'b0100;
    wait_gnt("t6");
    check("t6_start", 64'(mul_start), 64'd1);
    req = '0;
`ifdef MULT_ARB_TIMEOUT_EN
    wait_rsp("t6", cyc);
    check("t6_latency", 64'(cyc), 64'd65);
    check("t6_rsp_owner", 64'(rsp_valid), 64'd4);
    check("t6_rsp_err", 64'(rsp_err), 64'd1);
    check("t6_rsp_res", 64'(rsp_res), 64'd0);
`else
    acc_v = '0;
    all_busy = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step();
      acc_v |= rsp_valid;
      all_busy &= busy;
    end
    check("t6_no_rsp", 64'(acc_v), 64'd0);
    check("t6_busy_held", 64'(all_busy), 64'd1);
    check("t6_no_err", 64'(rsp_err), 64'd0);
`endif
    mdl_en = 1'b1;
    do_reset();
    check("end_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
